// File: rtl/s_axi_control_mc_if.sv
// s_axi_control_mc_if: AXI4-Lite bundle for the multi-channel control slave.
interface s_axi_control_mc_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;
  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/s_axi_control_mc.sv
// s_axi_control_mc: AXI4-Lite control slave with NUM_CH descriptor sets, auto-restart,
// maskable level interrupt and SLVERR on unmapped addresses.
module s_axi_control_mc #(
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_CH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  s_axi_control_mc_if.slave     s_axi,
  output logic [NUM_CH-1:0]     user_start,
  input  logic [NUM_CH-1:0]     user_done,
  input  logic [NUM_CH-1:0]     user_idle,
  output logic [32*NUM_CH-1:0]  byte_len,
  output logic [32*NUM_CH-1:0]  src_addr,
  output logic [32*NUM_CH-1:0]  dst_addr,
  output logic                  interrupt
);
  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_t;
  typedef enum logic {RDIDLE, RDDATA} rstate_t;
  wstate_t wstate, wnext;
  rstate_t rstate, rnext;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata, rmux;
  logic [7:0] waddr, raddr;
  logic [31:0] wdata, wmask;
  logic [3:0] wstrb;
  logic aw_hs, w_hs, ar_hs, w_ok, r_ok, wr, gie;
  logic [1:0] bresp, rresp;
  logic [NUM_CH-1:0] ier, isr, start, done, idle, auto_rs;
  logic [NUM_CH-1:0] ctrl_we, len_we, src_we, dst_we, done_clr, isr_tow;
  logic [NUM_CH-1:0][31:0] len_r, src_r, dst_r;

  function automatic logic mapped(input logic [7:0] a);
    return a[1:0] == 2'b00 && {1'b0, a} < 9'(16 + 16 * NUM_CH);
  endfunction

  assign awaddr = s_axi.AWADDR;
  assign raddr = s_axi.ARADDR[7:0];
  assign wdata = s_axi.WDATA;
  assign wstrb = s_axi.WSTRB;
  assign wmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign aw_hs = s_axi.AWVALID && wstate == WRIDLE;
  assign w_hs = s_axi.WVALID && wstate == WRDATA;
  assign ar_hs = s_axi.ARVALID && rstate == RDIDLE;
  assign w_ok = mapped(waddr);
  assign r_ok = mapped(raddr);
  assign wr = w_hs && w_ok;
  assign isr_tow = (wr && waddr == 8'h08) ? wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0] : '0;

  assign s_axi.AWREADY = wstate == WRIDLE;
  assign s_axi.WREADY = wstate == WRDATA;
  assign s_axi.BVALID = wstate == WRRESP;
  assign s_axi.BRESP = bresp;
  assign s_axi.ARREADY = rstate == RDIDLE;
  assign s_axi.RVALID = rstate == RDDATA;
  assign s_axi.RDATA = rdata;
  assign s_axi.RRESP = rresp;
  assign user_start = start;
  assign byte_len = len_r;
  assign src_addr = src_r;
  assign dst_addr = dst_r;

  always_comb begin
    wnext = aw_hs ? WRDATA : w_hs ? WRRESP : (wstate == WRRESP && s_axi.BREADY) ? WRIDLE : wstate;
    rnext = ar_hs ? RDDATA : (rstate == RDDATA && s_axi.RREADY) ? RDIDLE : rstate;
  end

  // Address decode for writes (latched AW address) and reads (live AR address)
  always_comb begin
    ctrl_we = '0;
    len_we = '0;
    src_we = '0;
    dst_we = '0;
    done_clr = '0;
    rmux = '0;
    if (raddr[7:4] == 4'h0)
      rmux = raddr[3:2] == 2'd0 ? 32'(gie) : raddr[3:2] == 2'd1 ? 32'(ier) : raddr[3:2] == 2'd2 ? 32'(isr) : '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ctrl_we[c] = wr && waddr == 8'(16 * c + 16);
      len_we[c] = wr && waddr == 8'(16 * c + 20);
      src_we[c] = wr && waddr == 8'(16 * c + 24);
      dst_we[c] = wr && waddr == 8'(16 * c + 28);
      done_clr[c] = ar_hs && raddr == 8'(16 * c + 16);
      if (raddr[7:4] == 4'(c + 1))
        rmux = raddr[3:2] == 2'd0 ? {24'b0, auto_rs[c], 4'b0, idle[c], done[c], start[c]} :
               raddr[3:2] == 2'd1 ? len_r[c] : raddr[3:2] == 2'd2 ? src_r[c] : dst_r[c];
    end
    if (!r_ok) rmux = '0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate <= WRIDLE;
      rstate <= RDIDLE;
      waddr <= '0;
      bresp <= '0;
      rdata <= '0;
      rresp <= '0;
      gie <= 1'b0;
      ier <= '0;
      isr <= '0;
      interrupt <= 1'b0;
      idle <= '0;
      start <= '0;
      done <= '0;
      auto_rs <= '0;
      len_r <= '0;
      src_r <= '0;
      dst_r <= '0;
    end else begin
      wstate <= wnext;
      rstate <= rnext;
      if (aw_hs) waddr <= awaddr[7:0];
      if (w_hs) bresp <= w_ok ? 2'b00 : 2'b10;
      if (ar_hs) begin
        rdata <= rmux;
        rresp <= r_ok ? 2'b00 : 2'b10;
      end
      if (wr && waddr == 8'h00 && wstrb[0]) gie <= wdata[0];
      if (wr && waddr == 8'h04) ier <= (wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]) | (ier & ~wmask[NUM_CH-1:0]);
      // A done set outranks a same-cycle toggle from the host
      isr <= (user_done & ier) | (isr ^ isr_tow);
      interrupt <= gie && |(isr & ier);
      idle <= user_idle;
      start <= (ctrl_we & {NUM_CH{wstrb[0] && wdata[0]}}) | (start & ~(user_done & ~auto_rs));
      done <= user_done | (done & ~done_clr);
      for (int c = 0; c < NUM_CH; c++) begin
        if (ctrl_we[c] && wstrb[0]) auto_rs[c] <= wdata[7];
        if (len_we[c]) len_r[c] <= (wdata & wmask) | (len_r[c] & ~wmask);
        if (src_we[c]) src_r[c] <= (wdata & wmask) | (src_r[c] & ~wmask);
        if (dst_we[c]) dst_r[c] <= (wdata & wmask) | (dst_r[c] & ~wmask);
      end
    end
  end
endmodule

// File: tb/tb_s_axi_control_mc.sv
// tb_s_axi_control_mc: directed bench; expected B/R responses are queued by the
// stimulus and popped by an independent monitor on each handshake.
module tb_s_axi_control_mc;
  localparam int N = 4;
  typedef struct packed {logic [31:0] d; logic [1:0] r;} rexp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] user_start, user_done, user_idle;
  logic [32*N-1:0] byte_len, src_addr, dst_addr;
  logic interrupt;
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_b[$];
  rexp_t exp_r[$];

  s_axi_control_mc_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  s_axi_control_mc #(.C_S_AXI_ADDR_WIDTH(8), .C_S_AXI_DATA_WIDTH(32), .NUM_CH(N)) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(bus),
    .user_start(user_start), .user_done(user_done), .user_idle(user_idle),
    .byte_len(byte_len), .src_addr(src_addr), .dst_addr(dst_addr), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int n);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s: no handshake within 50 cycles", name);
    end
  endtask

  always @(negedge clk) begin
    rexp_t e;
    if (bus.BVALID && bus.BREADY) begin
      if (exp_b.size() == 0) check("bresp_unexpected", 32'(bus.BRESP), 32'hFFFF_FFFF);
      else check("bresp", 32'(bus.BRESP), 32'(exp_b.pop_front()));
    end
    if (bus.RVALID && bus.RREADY) begin
      if (exp_r.size() == 0) check("rvalid_unexpected", bus.RDATA, 32'hDEAD_BEEF);
      else begin
        e = exp_r.pop_front();
        check("rdata", bus.RDATA, e.d);
        check("rresp", 32'(bus.RRESP), 32'(e.r));
      end
    end
  end

  task automatic aw_w(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [N-1:0] dn);
    int n;
    bus.AWADDR = a;
    bus.AWVALID = 1'b1;
    for (n = 0; n < 50 && !bus.AWREADY; n++) begin @(posedge clk); #1; end
    timeout("awready", n);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    bus.WDATA = d;
    bus.WSTRB = s;
    bus.WVALID = 1'b1;
    user_done = dn;
    for (n = 0; n < 50 && !bus.WREADY; n++) begin @(posedge clk); #1; end
    timeout("wready", n);
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    user_done = '0;
  endtask

  task automatic ar(input logic [7:0] a);
    int n;
    bus.ARADDR = a;
    bus.ARVALID = 1'b1;
    for (n = 0; n < 50 && !bus.ARREADY; n++) begin @(posedge clk); #1; end
    timeout("arready", n);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 50 && (exp_b.size() != 0 || exp_r.size() != 0); n++) begin @(posedge clk); #1; end
    timeout("response", n);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input logic [N-1:0] dn);
    exp_b.push_back(er);
    aw_w(a, d, s, dn);
    drain();
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] er);
    exp_r.push_back({d, er});
    ar(a);
    drain();
  endtask

  task automatic pulse(input int c);
    user_done[c] = 1'b1;
    @(posedge clk); #1;
    user_done = '0;
  endtask

  initial begin
    {bus.AWADDR, bus.AWVALID, bus.WDATA, bus.WSTRB, bus.WVALID, bus.ARADDR, bus.ARVALID} = '0;
    bus.BREADY = 1'b1;
    bus.RREADY = 1'b1;
    user_done = '0;
    user_idle = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(bus.AWREADY), 32'd1);
    check("rst_bvalid", 32'(bus.BVALID), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_arready", 32'(bus.ARREADY), 32'd1);
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_user_start", 32'(user_start), 32'd0);
    for (int a = 0; a < 'h50; a += 4) rd(8'(a), 32'd0, 2'b00);

    // byte-strobed descriptor writes
    wr(8'h24, 32'h0000_1000, 4'b0011, 2'b00, '0);
    check("len1_lo", byte_len[63:32], 32'h0000_1000);
    wr(8'h24, 32'hFFFF_FFFF, 4'b1100, 2'b00, '0);
    check("len1_hi", byte_len[63:32], 32'hFFFF_1000);
    rd(8'h24, 32'hFFFF_1000, 2'b00);
    wr(8'h48, 32'hA5A5_0001, 4'hF, 2'b00, '0);
    check("src3", src_addr[127:96], 32'hA5A5_0001);
    wr(8'h3C, 32'h1234_5678, 4'b0100, 2'b00, '0);
    check("dst2", dst_addr[95:64], 32'h0034_0000);
    rd(8'h3C, 32'h0034_0000, 2'b00);
    check("len0_untouched", byte_len[31:0], 32'd0);

    // start / done / idle / auto-restart
    wr(8'h10, 32'h1, 4'h1, 2'b00, '0);
    check("start0_set", 32'(user_start), 32'h1);
    pulse(0);
    check("start0_clr", 32'(user_start), 32'h0);
    rd(8'h10, 32'h2, 2'b00);
    rd(8'h10, 32'h0, 2'b00);
    user_idle = 4'b0010;
    @(posedge clk); #1;
    rd(8'h20, 32'h4, 2'b00);
    user_idle = '0;
    wr(8'h10, 32'h81, 4'h1, 2'b00, '0);
    pulse(0);
    check("start0_auto", 32'(user_start), 32'h1);
    rd(8'h10, 32'h83, 2'b00);
    rd(8'h10, 32'h81, 2'b00);
    wr(8'h10, 32'h0, 4'h1, 2'b00, '0);
    check("start0_no_clr_by_write", 32'(user_start), 32'h1);
    rd(8'h10, 32'h1, 2'b00);
    pulse(0);
    check("start0_clr2", 32'(user_start), 32'h0);
    wr(8'h10, 32'h1, 4'h1, 2'b00, 4'b0001);
    check("start0_set_vs_done", 32'(user_start), 32'h1);
    rd(8'h10, 32'h3, 2'b00);
    pulse(0);

    // interrupt path
    wr(8'h04, 32'h4, 4'hF, 2'b00, '0);
    wr(8'h00, 32'h1, 4'hF, 2'b00, '0);
    pulse(2);
    check("irq_not_yet", 32'(interrupt), 32'd0);
    @(posedge clk); #1;
    check("irq_set", 32'(interrupt), 32'd1);
    rd(8'h08, 32'h4, 2'b00);
    wr(8'h08, 32'h4, 4'hF, 2'b00, '0);
    check("irq_cleared", 32'(interrupt), 32'd0);
    rd(8'h08, 32'h0, 2'b00);
    pulse(2);
    wr(8'h08, 32'h4, 4'hF, 2'b00, 4'b0100);
    rd(8'h08, 32'h4, 2'b00);
    check("irq_set_wins", 32'(interrupt), 32'd1);
    wr(8'h00, 32'h0, 4'hF, 2'b00, '0);
    check("irq_gie_off", 32'(interrupt), 32'd0);
    wr(8'h00, 32'h1, 4'hF, 2'b00, '0);
    check("irq_gie_on", 32'(interrupt), 32'd1);
    wr(8'h08, 32'h4, 4'hF, 2'b00, '0);
    pulse(1);
    @(posedge clk); #1;
    rd(8'h08, 32'h0, 2'b00);
    check("irq_masked", 32'(interrupt), 32'd0);
    rd(8'h04, 32'h4, 2'b00);
    rd(8'h00, 32'h1, 2'b00);

    // unmapped and reserved
    wr(8'h12, 32'hFFFF_FFFF, 4'hF, 2'b10, '0);
    check("slverr_no_start", 32'(user_start), 32'h0);
    wr(8'h50, 32'hFFFF_FFFF, 4'hF, 2'b10, '0);
    wr(8'h26, 32'hFFFF_FFFF, 4'hF, 2'b10, '0);
    check("slverr_len_kept", byte_len[63:32], 32'hFFFF_1000);
    rd(8'h50, 32'h0, 2'b10);
    rd(8'h26, 32'h0, 2'b10);
    wr(8'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, '0);
    rd(8'h0C, 32'h0, 2'b00);

    // asynchronous reset mid-transaction
    wr(8'h40, 32'h1, 4'h1, 2'b00, '0);
    wr(8'h04, 32'hF, 4'hF, 2'b00, '0);
    pulse(3);
    @(posedge clk); #1;
    check("pre_rst_irq", 32'(interrupt), 32'd1);
    bus.BREADY = 1'b0;
    bus.RREADY = 1'b0;
    aw_w(8'h14, 32'h77, 4'hF, '0);
    ar(8'h14);
    check("pre_rst_bvalid", 32'(bus.BVALID), 32'd1);
    check("pre_rst_rvalid", 32'(bus.RVALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_bvalid", 32'(bus.BVALID), 32'd0);
    check("rst_mid_rvalid", 32'(bus.RVALID), 32'd0);
    check("rst_mid_awready", 32'(bus.AWREADY), 32'd1);
    check("rst_mid_arready", 32'(bus.ARREADY), 32'd1);
    check("rst_mid_irq", 32'(interrupt), 32'd0);
    check("rst_mid_start", 32'(user_start), 32'd0);
    check("rst_mid_len", byte_len[63:32], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.BREADY = 1'b1;
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 'h50; a += 4) rd(8'(a), 32'd0, 2'b00);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
